// File: rtl/stack_seq_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// stack_seq_if
//
// Purpose : Groups the signals between the stack sequencer and its
//           environment. The environment includes the op requester and the
//           external stack that supplies top/next and takes push/drop strobes.
//
// Signals :
//   op_valid, op, op_data : operation request, opcode and PUSH literal
//   op_ready              : sequencer can accept an operation
//   push, drop, D         : strobes to the external stack, push data word
//   top, next             : current top and second stack entries
//   depth                 : entry count tracked by the sequencer (7 bits)
//   err_ovf, err_udf      : sticky overflow / underflow flags
//
// Modports:
//   master : the environment (requester plus external stack)
//   slave  : the sequencer (stack_seq)
// -----------------------------------------------------------------------------
interface stack_seq_if #(
  parameter int WIDTH = 36
);
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] op_data;
  logic             push;
  logic [WIDTH-1:0] D;
  logic             drop;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] next;
  logic [6:0]       depth;
  logic             err_ovf;
  logic             err_udf;

  modport master (
    output op_valid, op, op_data, top, next,
    input  op_ready, push, D, drop, depth, err_ovf, err_udf
  );

  modport slave (
    input  op_valid, op, op_data, top, next,
    output op_ready, push, D, drop, depth, err_ovf, err_udf
  );
endinterface

// File: rtl/stack_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// stack_seq
//
// Purpose : Expands stack operations (PUSH, DROP, DUP, OVER, SWAP, NIP, NOP)
//           into sequences of one-cycle push/drop strobes for an external
//           stack. Every strobe is followed by a gap cycle, so strobes never
//           fall on adjacent cycles. The sequencer also tracks the stack depth.
//
// Ports   :
//   clk  - sole clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - stack_seq_if.slave: op_valid/op_ready/op/op_data request side,
//          push/drop/D strobes, top/next stack view, depth, err_ovf/err_udf
//
// Parameters:
//   WIDTH - stack word width in bits
//   DEPTH - stack capacity in words (at most 127, since depth is 7 bits)
//
// Configuration macro:
//   STACK_SEQ_CHECK_EN - when defined, ops that would underflow or overflow
//                        are turned into NOPs and set sticky err_udf/err_ovf.
//                        When undefined, every op executes, the error flags
//                        are tied low and depth wraps modulo 128.
// -----------------------------------------------------------------------------
module stack_seq #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst,
  stack_seq_if.slave  bus
);

  // depth is a 7-bit count, so the capacity must fit in it.
  if (DEPTH < 1 || DEPTH > 127) begin : g_bad_depth
    $error("stack_seq: DEPTH must be in 1..127");
  end

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_DROP = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_OVER = 3'd4;
  localparam logic [2:0] OP_SWAP = 3'd5;
  localparam logic [2:0] OP_NIP  = 3'd6;

  // Source of a pushed word.
  localparam logic [1:0] SRC_LIT  = 2'd0;
  localparam logic [1:0] SRC_TOP  = 2'd1;
  localparam logic [1:0] SRC_NEXT = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic       is_push;
    logic       is_drop;
    logic [1:0] src;
  } step_t;

  // Number of strobes an opcode expands to.
  function automatic logic [2:0] step_count(input logic [2:0] o);
    logic [2:0] n;
    n = 3'd0;
    case (o)
      OP_PUSH, OP_DROP, OP_DUP, OP_OVER: n = 3'd1;
      OP_SWAP:                           n = 3'd4;
      OP_NIP:                            n = 3'd3;
      default:                           n = 3'd0;
    endcase
    return n;
  endfunction

  // Kind and data source of step idx of opcode o.
  function automatic step_t step_decode(input logic [2:0] o, input logic [1:0] idx);
    step_t s;
    s = '{is_push: 1'b0, is_drop: 1'b0, src: SRC_LIT};
    case (o)
      OP_PUSH: s = '{is_push: 1'b1, is_drop: 1'b0, src: SRC_LIT};
      OP_DROP: s = '{is_push: 1'b0, is_drop: 1'b1, src: SRC_LIT};
      OP_DUP:  s = '{is_push: 1'b1, is_drop: 1'b0, src: SRC_TOP};
      OP_OVER: s = '{is_push: 1'b1, is_drop: 1'b0, src: SRC_NEXT};
      OP_SWAP: begin
        case (idx)
          2'd0, 2'd1: s = '{is_push: 1'b0, is_drop: 1'b1, src: SRC_LIT};
          2'd2:       s = '{is_push: 1'b1, is_drop: 1'b0, src: SRC_TOP};
          default:    s = '{is_push: 1'b1, is_drop: 1'b0, src: SRC_NEXT};
        endcase
      end
      OP_NIP: begin
        case (idx)
          2'd0, 2'd1: s = '{is_push: 1'b0, is_drop: 1'b1, src: SRC_LIT};
          default:    s = '{is_push: 1'b1, is_drop: 1'b0, src: SRC_TOP};
        endcase
      end
      default: s = '{is_push: 1'b0, is_drop: 1'b0, src: SRC_LIT};
    endcase
    return s;
  endfunction

  function automatic logic [WIDTH-1:0] src_mux(input logic [1:0]       src,
                                               input logic [WIDTH-1:0] lit,
                                               input logic [WIDTH-1:0] t,
                                               input logic [WIDTH-1:0] n);
    logic [WIDTH-1:0] v;
    case (src)
      SRC_TOP:  v = t;
      SRC_NEXT: v = n;
      default:  v = lit;
    endcase
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       step_q, step_d;      // strobes already launched for op_q
  logic [WIDTH-1:0] lit_q, lit_d;
  logic [WIDTH-1:0] top_q, top_d;        // top/next snapshot taken at acceptance
  logic [WIDTH-1:0] next_q, next_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             push_q, push_d;
  logic             drop_q, drop_d;
  logic [6:0]       depth_q, depth_d;

  logic             accept;
  logic             reject;              // accepted but executed as a NOP
  logic             udf_hit;
  logic             ovf_hit;

  // The first step is launched from the live inputs at the acceptance edge;
  // later steps come from the snapshot so SWAP/NIP see pre-drop values.
  step_t            first_step;
  logic [WIDTH-1:0] first_val;
  step_t            cont_step;
  logic [WIDTH-1:0] cont_val;

  assign accept     = bus.op_valid && (state_q == IDLE);

  assign first_step = step_decode(bus.op, 2'd0);
  assign first_val  = src_mux(first_step.src, bus.op_data, bus.top, bus.next);
  assign cont_step  = step_decode(op_q, step_q[1:0]);
  assign cont_val   = src_mux(cont_step.src, lit_q, top_q, next_q);

`ifdef STACK_SEQ_CHECK_EN
  localparam logic [6:0] DEPTH_MAX = 7'(DEPTH);

  function automatic logic [6:0] entries_needed(input logic [2:0] o);
    logic [6:0] n;
    case (o)
      OP_DROP, OP_DUP:          n = 7'd1;
      OP_OVER, OP_SWAP, OP_NIP: n = 7'd2;
      default:                  n = 7'd0;
    endcase
    return n;
  endfunction

  function automatic logic is_net_push(input logic [2:0] o);
    return (o == OP_PUSH) || (o == OP_DUP) || (o == OP_OVER);
  endfunction

  logic ovf_q, udf_q;

  // depth_q is settled whenever the FSM is IDLE: the last strobe of the
  // previous op ended at least one cycle earlier.
  assign udf_hit = accept && (depth_q < entries_needed(bus.op));
  assign ovf_hit = accept && is_net_push(bus.op) && (depth_q == DEPTH_MAX);
  assign reject  = udf_hit || ovf_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | ovf_hit;
      udf_q <= udf_q | udf_hit;
    end
  end

  assign bus.err_ovf = ovf_q;
  assign bus.err_udf = udf_q;
`else
  assign udf_hit     = 1'b0;
  assign ovf_hit     = 1'b0;
  assign reject      = udf_hit | ovf_hit;
  assign bus.err_ovf = 1'b0;
  assign bus.err_udf = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    step_d  = step_q;
    lit_d   = lit_q;
    top_d   = top_q;
    next_d  = next_q;
    d_d     = d_q;
    push_d  = 1'b0;
    drop_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          lit_d  = bus.op_data;
          top_d  = bus.top;
          next_d = bus.next;
          if (reject || (step_count(bus.op) == 3'd0)) begin
            // Empty step list: a single ready-low cycle without strobes.
            op_d    = OP_NOP;
            step_d  = 3'd0;
            state_d = GAP;
          end else begin
            op_d    = bus.op;
            step_d  = 3'd1;
            state_d = PULSE;
            push_d  = first_step.is_push;
            drop_d  = first_step.is_drop;
            if (first_step.is_push) begin
              d_d = first_val;
            end
          end
        end
      end

      PULSE: begin
        state_d = GAP;
      end

      GAP: begin
        if (step_q < step_count(op_q)) begin
          step_d  = step_q + 3'd1;
          state_d = PULSE;
          push_d  = cont_step.is_push;
          drop_d  = cont_step.is_drop;
          if (cont_step.is_push) begin
            d_d = cont_val;
          end
        end else begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // depth follows the strobe that is active during this cycle.
  assign depth_d = depth_q + 7'(push_q) - 7'(drop_q);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      step_q  <= 3'd0;
      lit_q   <= '0;
      top_q   <= '0;
      next_q  <= '0;
      d_q     <= '0;
      push_q  <= 1'b0;
      drop_q  <= 1'b0;
      depth_q <= 7'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      step_q  <= step_d;
      lit_q   <= lit_d;
      top_q   <= top_d;
      next_q  <= next_d;
      d_q     <= d_d;
      push_q  <= push_d;
      drop_q  <= drop_d;
      depth_q <= depth_d;
    end
  end

  assign bus.op_ready = (state_q == IDLE);
  assign bus.push     = push_q;
  assign bus.drop     = drop_q;
  assign bus.D        = d_q;
  assign bus.depth    = depth_q;

endmodule

// File: tb/tb_stack_seq.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_stack_seq
//
// Directed bench for stack_seq. The driver issues ops and pushes the expected
// strobes (kind, pushed value, cycle) and the expected op_ready return cycle
// into queues. A monitor on the falling edge pops and compares whenever a
// strobe or an op_ready rise appears, and models the external stack to drive
// top/next.
// -----------------------------------------------------------------------------
module tb_stack_seq;
  localparam int WIDTH = 36;
  localparam int DEPTH = 64;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_PUSH = 3'd1;
  localparam logic [2:0] OP_DROP = 3'd2;
  localparam logic [2:0] OP_DUP  = 3'd3;
  localparam logic [2:0] OP_OVER = 3'd4;
  localparam logic [2:0] OP_SWAP = 3'd5;
  localparam logic [2:0] OP_NIP  = 3'd6;
  localparam logic [2:0] OP_NOP7 = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;

  stack_seq_if #(.WIDTH(WIDTH)) bus ();

  stack_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               is_push;
    logic [WIDTH-1:0] val;
    int               at_edge;
  } exp_t;

  exp_t             sb[$];
  int               rdy_q[$];
  logic [WIDTH-1:0] stk[$];       // external stack model, index 0 is top

  int e      = 0;                 // rising edges seen so far
  int checks = 0;
  int errors = 0;

  always @(posedge clk) e <= e + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, e);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  bit               prev_strobe = 1'b0;
  bit               prev_ready  = 1'b1;
  logic [WIDTH-1:0] prev_d      = '0;
  exp_t             mon_x;
  int               mon_r;

  always @(negedge clk) begin
    if (rst) begin
      prev_strobe = 1'b0;
      prev_ready  = 1'b1;
      prev_d      = bus.D;
    end else begin
      if (bus.push || bus.drop) begin
        check("no_overlap", 64'(bus.push & bus.drop), 64'd0);
        check("no_adjacent", 64'(prev_strobe), 64'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: push=%0d drop=%0d D=%0d at edge %0d, required none",
                   bus.push, bus.drop, bus.D, e);
        end else begin
          mon_x = sb.pop_front();
          check("strobe_kind_push", 64'(bus.push), 64'(mon_x.is_push));
          if (mon_x.is_push) check("push_D", 64'(bus.D), 64'(mon_x.val));
          check("strobe_cycle", 64'(e), 64'(mon_x.at_edge));
        end
        if (bus.push) stk.push_front(bus.D);
        else if (stk.size() > 0) void'(stk.pop_front());
      end else begin
        check("D_hold", 64'(bus.D), 64'(prev_d));
      end
      if (bus.op_ready && !prev_ready) begin
        if (rdy_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: op_ready rose at edge %0d, required no rise", e);
        end else begin
          mon_r = rdy_q.pop_front();
          check("ready_return", 64'(e), 64'(mon_r));
        end
      end
      prev_strobe = bus.push || bus.drop;
      prev_ready  = bus.op_ready;
      prev_d      = bus.D;
    end
    bus.top  = (stk.size() > 0) ? stk[0] : '0;
    bus.next = (stk.size() > 1) ? stk[1] : '0;
  end

  // ---------------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------------
  // steps: one character per strobe, "P" push or "D" drop; v0..v3 are the
  // hand-computed pushed values for the matching step.
  task automatic issue(input logic [2:0]       o,
                       input logic [WIDTH-1:0] d,
                       input string            steps,
                       input logic [WIDTH-1:0] v0 = '0,
                       input logic [WIDTH-1:0] v1 = '0,
                       input logic [WIDTH-1:0] v2 = '0,
                       input logic [WIDTH-1:0] v3 = '0,
                       input bit               hold = 1'b0);
    logic [WIDTH-1:0] v[4];
    exp_t             t;
    int               k;
    int               n;
    int               waited;
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    bus.op_valid = 1'b1;
    bus.op       = o;
    bus.op_data  = d;
    waited = 0;
    while (!bus.op_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.op_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: op_ready=0 after %0d cycles, required 1", waited);
      bus.op_valid = 1'b0;
      return;
    end
    k = e + 1;
    n = steps.len();
    for (int i = 0; i < n; i++) begin
      t.is_push = (steps.getc(i) == "P");
      t.val     = v[i];
      t.at_edge = k + 2 * i;
      sb.push_back(t);
    end
    rdy_q.push_back((n == 0) ? k + 1 : k + 2 * n);
    @(posedge clk);
    #1;
    if (!hold) bus.op_valid = 1'b0;
  endtask

  task automatic settle();
    int c;
    c = 0;
    while ((sb.size() != 0 || rdy_q.size() != 0 || !bus.op_ready) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("settle_pending", 64'(sb.size() + rdy_q.size()), 64'd0);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int k_sw;

  initial begin
    bus.op_valid = 1'b0;
    bus.op       = OP_NOP;
    bus.op_data  = '0;
    bus.top      = '0;
    bus.next     = '0;
    rst          = 1'b1;
    repeat (2) @(negedge clk);

    check("rst_op_ready", 64'(bus.op_ready), 64'd1);
    check("rst_push",     64'(bus.push),     64'd0);
    check("rst_drop",     64'(bus.drop),     64'd0);
    check("rst_D",        64'(bus.D),        64'd0);
    check("rst_depth",    64'(bus.depth),    64'd0);
    check("rst_err_ovf",  64'(bus.err_ovf),  64'd0);
    check("rst_err_udf",  64'(bus.err_udf),  64'd0);
    rst = 1'b0;

    // Three literal pushes: stack becomes [3,137,16].
    issue(OP_PUSH, 36'd16,  "P", 36'd16);
    issue(OP_PUSH, 36'd137, "P", 36'd137);
    issue(OP_PUSH, 36'd3,   "P", 36'd3);
    settle();
    check("depth_push3", 64'(bus.depth), 64'd3);

    // SWAP pushes the snapshot values even though top/next move during drops.
    issue(OP_SWAP, '0, "DDPP", '0, '0, 36'd3, 36'd137);
    settle();
    check("depth_swap1", 64'(bus.depth), 64'd3);
    issue(OP_SWAP, '0, "DDPP", '0, '0, 36'd137, 36'd3);
    settle();
    check("depth_swap2", 64'(bus.depth), 64'd3);

    // DUP then NIP: [3,3,137,16] then [3,137,16].
    issue(OP_DUP, '0, "P",   36'd3);
    issue(OP_NIP, '0, "DDP", '0, '0, 36'd3);
    settle();
    check("depth_dup_nip", 64'(bus.depth), 64'd3);

    // OVER: [137,3,137,16]; DROP: [3,137,16]; both NOP codes do nothing.
    issue(OP_OVER, 36'd99, "P", 36'd137);
    settle();
    check("depth_over", 64'(bus.depth), 64'd4);
    issue(OP_DROP, '0, "D");
    issue(OP_NOP,  36'd55, "");
    issue(OP_NOP7, 36'd77, "");
    settle();
    check("depth_drop_nop", 64'(bus.depth), 64'd3);

    // Back-to-back DUPs with op_valid held high.
    issue(OP_DUP, '0, "P", 36'd3, '0, '0, '0, 1'b1);
    issue(OP_DUP, '0, "P", 36'd3, '0, '0, '0, 1'b1);
    issue(OP_DUP, '0, "P", 36'd3, '0, '0, '0, 1'b0);
    settle();
    check("depth_dup3", 64'(bus.depth), 64'd6);
    issue(OP_DROP, '0, "D", '0, '0, '0, '0, 1'b1);
    issue(OP_DROP, '0, "D", '0, '0, '0, '0, 1'b1);
    issue(OP_DROP, '0, "D");
    settle();
    check("depth_drop3", 64'(bus.depth), 64'd3);

    // Reset in the gap after the second drop of a SWAP.
    issue(OP_SWAP, '0, "DDPP", '0, '0, 36'd3, 36'd137);
    k_sw = e;
    while (e < k_sw + 3) @(negedge clk);
    check("swap_pending_pushes", 64'(sb.size()), 64'd2);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_op_ready", 64'(bus.op_ready), 64'd1);
    check("async_rst_push",     64'(bus.push),     64'd0);
    check("async_rst_drop",     64'(bus.drop),     64'd0);
    check("async_rst_depth",    64'(bus.depth),    64'd0);
    check("async_rst_D",        64'(bus.D),        64'd0);
    sb.delete();
    rdy_q.delete();
    stk.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First op straight after reset release; remaining SWAP pushes must not appear.
    issue(OP_PUSH, 36'h8_0000_0042, "P", 36'h8_0000_0042);
    settle();
    check("depth_after_rst", 64'(bus.depth), 64'd1);

`ifdef STACK_SEQ_CHECK_EN
    issue(OP_DROP, '0, "D");
    issue(OP_DROP, '0, "");
    settle();
    check("chk_udf_flag",  64'(bus.err_udf), 64'd1);
    check("chk_udf_depth", 64'(bus.depth),   64'd0);
    check("chk_udf_noovf", 64'(bus.err_ovf), 64'd0);
    for (int i = 0; i < DEPTH; i++) begin
      issue(OP_PUSH, 36'(i + 1), "P", 36'(i + 1));
    end
    settle();
    check("chk_full_depth", 64'(bus.depth), 64'(DEPTH));
    issue(OP_PUSH, 36'd500, "");
    settle();
    check("chk_ovf_flag",  64'(bus.err_ovf), 64'd1);
    check("chk_ovf_depth", 64'(bus.depth),   64'(DEPTH));
    check("chk_udf_sticky", 64'(bus.err_udf), 64'd1);
`else
    // Without checking, underflow executes and depth wraps.
    issue(OP_DROP, '0, "D");
    issue(OP_DROP, '0, "D");
    settle();
    check("wrap_depth_127", 64'(bus.depth),   64'd127);
    check("nochk_err_udf",  64'(bus.err_udf), 64'd0);
    issue(OP_PUSH, 36'd5, "P", 36'd5);
    settle();
    check("wrap_depth_0",   64'(bus.depth),   64'd0);
    check("nochk_err_ovf",  64'(bus.err_ovf), 64'd0);
`endif

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
